// File: rtl/aespim_sequencer.sv
// aespim_sequencer: drives aespim_accelerator through one AES block encryption.
// Takes a start command, then a 32-bit word stream made up of key0, the
// plaintext and round keys 1..NR. The stream is forwarded to the accelerator
// with the op code and shift-row code for each beat, and the 4 ciphertext
// words are returned on a valid/ready output stream.
// Optional feature: define AESPIM_SEQ_PERF_EN to build the busy-cycle counter
// that feeds perf_cyc_o. Without it, perf_cyc_o is tied to zero.
module aespim_sequencer #(
  parameter int NR     = 10,
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       perf_cyc_o,
  output logic              acc_start_o,
  output logic [4:0]        acc_op_o,
  output logic [WORD_W-1:0] acc_data_o,
  input  logic [WORD_W-1:0] acc_data_i
);

  localparam int RW = $clog2(NR + 1);
  localparam logic [RW-1:0] RND_FIRST = RW'(1);
  localparam logic [RW-1:0] RND_LAST  = RW'(NR - 1);

  // Accelerator op codes (acc_op_o[2:0]). The key-expansion codes are never issued.
  localparam logic [2:0] OP_LD   = 3'b000;
  localparam logic [2:0] OP_ST   = 3'b001;
  localparam logic [2:0] OP_ENCI = 3'b100;
  localparam logic [2:0] OP_ENCM = 3'b101;
  localparam logic [2:0] OP_ENCF = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KEY   = 3'd1,
    S_INIT  = 3'd2,
    S_ROUND = 3'd3,
    S_FINAL = 3'd4,
    S_STORE = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      beat_q, beat_d;
  logic [RW-1:0]   rnd_q, rnd_d;
  logic            last_beat;
  logic            cmd_fire;

  assign last_beat = (beat_q == 2'd3);
  assign cmd_fire  = (state_q == S_IDLE) && cmd_valid_i;

  // Next-state logic: the beat advances only on an accepted word, and the
  // wrap from 3 to 0 moves the phase and round on.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path through this block infers a latch.
    state_d = state_q;
    beat_d  = beat_q;
    rnd_d   = rnd_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          state_d = S_KEY;
          beat_d  = 2'd0;
          rnd_d   = RND_FIRST;
        end
      end
      S_KEY, S_INIT, S_ROUND, S_FINAL: begin
        if (in_valid_i) begin
          beat_d = beat_q + 2'd1;
          if (last_beat) begin
            unique case (state_q)
              S_KEY:   state_d = S_INIT;
              S_INIT:  state_d = S_ROUND;
              S_ROUND: begin
                if (rnd_q == RND_LAST) state_d = S_FINAL;
                else                   rnd_d   = rnd_q + RW'(1);
              end
              default: state_d = S_STORE;
            endcase
          end
        end
      end
      S_STORE: begin
        if (out_ready_i) begin
          beat_d = beat_q + 2'd1;
          if (last_beat) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = 2'd0;
        rnd_d   = RND_FIRST;
      end
    endcase
  end

  // Sequencer state registers; reset aborts any block in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) begin
      state_q <= S_IDLE;
      beat_q  <= 2'd0;
      rnd_q   <= RND_FIRST;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rnd_q   <= rnd_d;
    end
  end

  // Output decode: streams pass straight through so a word is accepted in the
  // same cycle it is offered; a stalled beat keeps its op with start low.
  always_comb begin
    cmd_ready_o = (state_q == S_IDLE);
    busy_o      = (state_q != S_IDLE);
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    acc_start_o = 1'b0;
    acc_data_o  = '0;
    acc_op_o    = {2'b00, OP_LD};
    unique case (state_q)
      S_KEY: begin
        in_ready_o  = 1'b1;
        acc_start_o = in_valid_i;
        acc_data_o  = in_data_i;
        acc_op_o    = {2'b00, OP_LD};
      end
      S_INIT: begin
        in_ready_o  = 1'b1;
        acc_start_o = in_valid_i;
        acc_data_o  = in_data_i;
        acc_op_o    = {2'b00, OP_ENCI};
      end
      S_ROUND: begin
        in_ready_o  = 1'b1;
        acc_start_o = in_valid_i;
        acc_data_o  = in_data_i;
        acc_op_o    = {beat_q, OP_ENCM};
      end
      S_FINAL: begin
        in_ready_o  = 1'b1;
        acc_start_o = in_valid_i;
        acc_data_o  = in_data_i;
        acc_op_o    = {beat_q, OP_ENCF};
      end
      S_STORE: begin
        out_valid_o = 1'b1;
        out_data_o  = acc_data_i;
        acc_start_o = out_ready_i;
        acc_op_o    = {2'b00, OP_ST};
      end
      default: ;
    endcase
  end

  // done pulses in the same cycle the last ciphertext word is taken.
  assign done_o = (state_q == S_STORE) && last_beat && out_ready_i;

`ifdef AESPIM_SEQ_PERF_EN
  logic [15:0] cyc_q;
  logic [15:0] cyc_inc;
  logic [15:0] perf_q;

  assign cyc_inc = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;

  // Busy-cycle counter: cleared on command accept, saturating; its count
  // including the done cycle is captured when done pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q  <= 16'd0;
      perf_q <= 16'd0;
    end else begin
      if (cmd_fire)    cyc_q <= 16'd0;
      else if (busy_o) cyc_q <= cyc_inc;
      if (done_o)      perf_q <= cyc_inc;
    end
  end

  assign perf_cyc_o = perf_q;
`else
  assign perf_cyc_o = 16'd0;
`endif

endmodule

// File: tb/tb_aespim_sequencer.sv
// Bench for aespim_sequencer. A behavioural accelerator model consumes the
// issued ops and computes AES rounds, so ciphertext is right only if every
// word reaches it once, in order, under the right op. Expected ciphertext
// comes from published FIPS-197 vectors and is queued per block, then popped
// as output words are accepted.
module tb_aespim_sequencer;

  localparam int NR  = 10;
  localparam int NIN = 4 * NR + 8;
  localparam int NOP = 4 * NR + 12;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i, cmd_ready_o;
  logic        in_valid_i, in_ready_o;
  logic [31:0] in_data_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] out_data_o;
  logic        busy_o, done_o;
  logic [15:0] perf_cyc_o;
  logic        acc_start_o;
  logic [4:0]  acc_op_o;
  logic [31:0] acc_data_o, acc_data_i;

  always #5 clk_i = ~clk_i;

  aespim_sequencer #(.NR(NR), .WORD_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .busy_o(busy_o), .done_o(done_o), .perf_cyc_o(perf_cyc_o),
    .acc_start_o(acc_start_o), .acc_op_o(acc_op_o),
    .acc_data_o(acc_data_o), .acc_data_i(acc_data_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- AES helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gm(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] c0, c1, c2, c3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
        b[4*c]   = xt(c0) ^ xt(c1) ^ c1 ^ c2 ^ c3;
        b[4*c+1] = c0 ^ xt(c1) ^ xt(c2) ^ c2 ^ c3;
        b[4*c+2] = c0 ^ c1 ^ xt(c2) ^ xt(c3) ^ c3;
        b[4*c+3] = xt(c0) ^ c0 ^ c1 ^ c2 ^ xt(c3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ rk;
  endfunction

  // Expected op for the k-th start of a block: LDx4, ENCIx4, ENCMx4(NR-1), ENCFx4, STx4.
  function automatic logic [4:0] exp_op(input int k);
    if (k < 4)                return 5'b00000;
    if (k < 8)                return 5'b00100;
    if (k < 8 + 4 * (NR - 1)) return {2'(k % 4), 3'b101};
    if (k < 8 + 4 * NR)       return {2'(k % 4), 3'b110};
    return 5'b00001;
  endfunction

  // ---------------- accelerator model ----------------
  logic [1:0]   mb_q;
  logic [127:0] key_q, st_q;
  logic [31:0]  rk_q [4];
  logic [4:0]   issue_log [$];

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mb_q  <= 2'd0;
      key_q <= '0;
      st_q  <= '0;
    end else if (acc_start_o) begin
      issue_log.push_back(acc_op_o);
      mb_q <= mb_q + 2'd1;
      case (acc_op_o[2:0])
        3'b000: key_q[127-32*int'(mb_q) -: 32] <= acc_data_o;
        3'b100: st_q[127-32*int'(mb_q) -: 32] <= acc_data_o ^ key_q[127-32*int'(mb_q) -: 32];
        3'b101, 3'b110: begin
          if (mb_q == 2'd3)
            st_q <= aes_round(st_q, {rk_q[0], rk_q[1], rk_q[2], acc_data_o}, acc_op_o[2:0] == 3'b110);
          else
            rk_q[mb_q] <= acc_data_o;
        end
        default: ;
      endcase
    end
  end

  assign acc_data_i = st_q[127-32*int'(mb_q) -: 32];

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    bit           in_gap;
    bit           out_gap;
    bit           hold_cmd;
    int           abort_wi;
    int           exp_busy;
  } vec_t;

  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;

  vec_t        vecs [6];
  logic [31:0] sb_q [$];
  bit          prev_hold = 1'b0;

  task automatic run_block(input int t);
    vec_t        v;
    logic [31:0] w    [0:4*NR+3];
    logic [31:0] strm [0:NIN-1];
    logic [31:0] tw;
    logic [31:0] expw;
    logic [7:0]  rc;
    int          wi, oc, cyc, busy_cnt, ocyc, log_base;
    bit          accepted, fin, aborted;
    v = vecs[t];
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = v.key[127-32*i -: 32];
    for (int i = 4; i < 4 * NR + 4; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = subw({tw[23:0], tw[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int k = 0; k < NIN; k++)
      strm[k] = (k < 4) ? w[k] : (k < 8) ? v.pt[127-32*(k-4) -: 32] : w[k-4];
    for (int i = 0; i < 4; i++) sb_q.push_back(v.ct[127-32*i -: 32]);
    log_base = issue_log.size();
    wi = 0; oc = 0; cyc = 0; busy_cnt = 0; ocyc = 0;
    accepted = 1'b0; fin = 1'b0; aborted = 1'b0;

    while (!fin && cyc < 2000) begin
      @(negedge clk_i);
      cmd_valid_i = !accepted || v.hold_cmd;
      in_valid_i  = (wi < NIN) && (!v.in_gap || (cyc % 2 == 0));
      if (in_valid_i) in_data_i = strm[wi];
      else            in_data_i = $urandom();
      out_ready_i = v.out_gap ? (ocyc % 4 == 3) : 1'b1;
      #1;
      if (v.abort_wi != 0 && wi == v.abort_wi) begin
        check("abort_point_round5_beat2", acc_op_o, 5'b10101);
        rst_ni = 1'b0;
        #1;
        check("rst_mid_busy", busy_o, 1'b0);
        check("rst_mid_start", acc_start_o, 1'b0);
        check("rst_mid_op", acc_op_o, 5'd0);
        check("rst_mid_acc_data", acc_data_o, 32'd0);
        check("rst_mid_out_valid", out_valid_o, 1'b0);
        check("rst_mid_out_data", out_data_o, 32'd0);
        check("rst_mid_done", done_o, 1'b0);
        check("rst_mid_in_ready", in_ready_o, 1'b0);
        check("rst_mid_perf", perf_cyc_o, 16'd0);
        cmd_valid_i = 1'b0;
        in_valid_i  = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("rst_release_cmd_ready", cmd_ready_o, 1'b1);
        check("rst_release_busy", busy_o, 1'b0);
        sb_q.delete();
        aborted = 1'b1;
        fin = 1'b1;
      end else begin
        if (cyc == 0 && prev_hold) check("b2b_accept_after_done", cmd_ready_o, 1'b1);
        if (!accepted && cmd_ready_o) accepted = 1'b1;
        if (busy_o) busy_cnt++;
        if (in_valid_i && in_ready_o) wi++;
        if (out_valid_o) begin
          if (out_ready_i) begin
            if (sb_q.size() == 0) check("unexpected_out_word", 1'b1, 1'b0);
            else begin
              expw = sb_q.pop_front();
              check($sformatf("ct_word%0d_blk%0d", oc, t), out_data_o, expw);
            end
            oc++;
          end
          ocyc++;
        end
        if (done_o) begin
          check("done_on_4th_word", oc, 4);
          check("all_words_consumed", wi, NIN);
          if (v.exp_busy != 0) check("busy_cycles", busy_cnt, v.exp_busy);
          fin = 1'b1;
        end
      end
      cyc++;
    end
    if (!fin) check("block_timeout", 1'b0, 1'b1);

    if (fin && !aborted) begin
      @(posedge clk_i);
      #1;
      check("idle_after_done", busy_o, 1'b0);
      check("cmd_ready_after_done", cmd_ready_o, 1'b1);
`ifdef AESPIM_SEQ_PERF_EN
      check("perf_cyc", perf_cyc_o, busy_cnt);
`else
      check("perf_cyc_off", perf_cyc_o, 16'd0);
`endif
      check("sb_drained", sb_q.size(), 0);
      check("op_count", issue_log.size() - log_base, NOP);
      for (int k = 0; k < NOP && log_base + k < issue_log.size(); k++)
        check($sformatf("op_trace%0d", k), issue_log[log_base + k], exp_op(k));
    end
    if (!v.hold_cmd) cmd_valid_i = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    prev_hold   = v.hold_cmd && !aborted;
  endtask

  initial begin
    vecs[0] = '{C1K, C1P, C1C, 1'b0, 1'b0, 1'b0, 0,  52};
    vecs[1] = '{C1K, C1P, C1C, 1'b1, 1'b1, 1'b0, 0,  0};
    vecs[2] = '{BK,  BP,  BC,  1'b0, 1'b0, 1'b1, 0,  52};
    vecs[3] = '{C1K, C1P, C1C, 1'b0, 1'b0, 1'b0, 0,  52};
    vecs[4] = '{C1K, C1P, C1C, 1'b0, 1'b0, 1'b0, 26, 0};
    vecs[5] = '{C1K, C1P, C1C, 1'b0, 1'b0, 1'b0, 0,  52};

    rst_ni      = 1'b0;
    cmd_valid_i = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = 32'hA5A5_5A5A;
    out_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_cmd_ready", cmd_ready_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_in_ready", in_ready_o, 1'b0);
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_out_data", out_data_o, 32'd0);
    check("rst_done", done_o, 1'b0);
    check("rst_perf", perf_cyc_o, 16'd0);
    check("rst_acc_start", acc_start_o, 1'b0);
    check("rst_acc_op", acc_op_o, 5'd0);
    check("rst_acc_data", acc_data_o, 32'd0);
    rst_ni = 1'b1;

    // Idle with stray input traffic: nothing is accepted or issued.
    @(negedge clk_i);
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    #1;
    check("idle_in_ready", in_ready_o, 1'b0);
    check("idle_acc_start", acc_start_o, 1'b0);
    check("idle_acc_data", acc_data_o, 32'd0);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;

    for (int t = 0; t < 6; t++) run_block(t);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
